// File: rtl/wu_decode_if.sv
// wu_decode_if: words from wu_memory, commands to the operation controller.
// Fetch stall and sticky error; desc_count exists with WU_DECODE_DESC_COUNT_EN.
interface wu_decode_if #(
   parameter int OPT_PER_INST = 3,
   parameter int OPT_TYPE_W   = 8,
   parameter int OPT_VALUE_W  = 8
);
   logic                                wum__wud__valid;
   logic [1:0]                          wum__wud__icntl;
   logic [1:0]                          wum__wud__dcntl;
   logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wum__wud__option_type;
   logic [OPT_PER_INST*OPT_VALUE_W-1:0] wum__wud__option_value;
   logic                                wud__wuf__stall;
   logic                                wud__odc__valid;
   logic                                odc__wud__ready;
   logic [OPT_VALUE_W-1:0]              wud__odc__op;
   logic [OPT_VALUE_W-1:0]              wud__odc__num_lanes;
   logic [OPT_VALUE_W-1:0]              wud__odc__stream_size;
   logic [OPT_VALUE_W-1:0]              wud__odc__tgt;
   logic                                wud__sys__err;
`ifdef WU_DECODE_DESC_COUNT_EN
   logic [3:0]                          wud__odc__desc_count;

   modport master (
      output wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
      output wum__wud__option_type, wum__wud__option_value,
      output odc__wud__ready,
      input  wud__wuf__stall, wud__odc__valid, wud__odc__op,
      input  wud__odc__num_lanes, wud__odc__stream_size, wud__odc__tgt,
      input  wud__sys__err, wud__odc__desc_count
   );

   modport slave (
      input  wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
      input  wum__wud__option_type, wum__wud__option_value,
      input  odc__wud__ready,
      output wud__wuf__stall, wud__odc__valid, wud__odc__op,
      output wud__odc__num_lanes, wud__odc__stream_size, wud__odc__tgt,
      output wud__sys__err, wud__odc__desc_count
   );
`else
   modport master (
      output wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
      output wum__wud__option_type, wum__wud__option_value,
      output odc__wud__ready,
      input  wud__wuf__stall, wud__odc__valid, wud__odc__op,
      input  wud__odc__num_lanes, wud__odc__stream_size, wud__odc__tgt,
      input  wud__sys__err
   );

   modport slave (
      input  wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
      input  wum__wud__option_type, wum__wud__option_value,
      input  odc__wud__ready,
      output wud__wuf__stall, wud__odc__valid, wud__odc__op,
      output wud__odc__num_lanes, wud__odc__stream_size, wud__odc__tgt,
      output wud__sys__err
   );
`endif
endinterface

// File: rtl/wu_decode.sv
// wu_decode: assembles instruction words into commands queued in a FWFT FIFO.
// Optional per-command descriptor count with WU_DECODE_DESC_COUNT_EN.
module wu_decode #(
   parameter int OPT_PER_INST = 3,
   parameter int OPT_TYPE_W   = 8,
   parameter int OPT_VALUE_W  = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int MGR_ID_W     = 8
) (
   input logic                clk,
   input logic                reset_poweron,
   wu_decode_if.slave         bus,
   input logic [MGR_ID_W-1:0] sys__mgr__mgrId
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int VW = OPT_VALUE_W;
   localparam int TW = OPT_TYPE_W;
   localparam logic [TW-1:0] T_NOP   = TW'(0);
   localparam logic [TW-1:0] T_OP    = TW'(1);
   localparam logic [TW-1:0] T_LANES = TW'(2);
   localparam logic [TW-1:0] T_SSIZE = TW'(3);
   localparam logic [TW-1:0] T_TGT   = TW'(4);

   typedef enum logic {IDLE, IN_INST} state_t;

   typedef struct packed {
`ifdef WU_DECODE_DESC_COUNT_EN
      logic [3:0]    dcnt;
`endif
      logic [VW-1:0] op;
      logic [VW-1:0] lanes;
      logic [VW-1:0] ssize;
      logic [VW-1:0] tgt;
   } cmd_t;

   state_t        state;
   cmd_t          acc;
   cmd_t          nxt;
   cmd_t          head;
   cmd_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nx;
   logic          stall;
   logic          err;
   logic [TW-1:0] t;
   logic [VW-1:0] v;
   logic          bad_type;
   logic          vld;
   logic          som;
   logic          eom;
   logic          accept;
   logic          proto_err;
   logic          push;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          drop;
   logic          unused_ok;

   assign vld = bus.wum__wud__valid;
   assign som = bus.wum__wud__icntl[0];
   assign eom = bus.wum__wud__icntl[1];

   // Any SOM-flagged word restarts assembly from a clean slate.
   always_comb begin
      nxt      = som ? '0 : acc;
      bad_type = 1'b0;
      t        = '0;
      v        = '0;
      for (int i = 0; i < OPT_PER_INST; i++) begin
         t = bus.wum__wud__option_type[i*TW +: TW];
         v = bus.wum__wud__option_value[i*VW +: VW];
         unique case (1'b1)
            t == T_NOP:   ;
            t == T_OP:    nxt.op    = v;
            t == T_LANES: nxt.lanes = v;
            t == T_SSIZE: nxt.ssize = v;
            t == T_TGT:   nxt.tgt   = v;
            default:      bad_type  = 1'b1;
         endcase
      end
`ifdef WU_DECODE_DESC_COUNT_EN
      if (bus.wum__wud__dcntl[0] && nxt.dcnt != 4'hf)
         nxt.dcnt = nxt.dcnt + 4'd1;
`endif
   end

   assign accept    = vld && (som || state == IN_INST);
   assign proto_err = vld && ((state == IN_INST) ? som : !som);
   assign push      = accept && eom;
   assign pop       = (count != '0) && bus.odc__wud__ready;
   assign full      = count == (AW+1)'(FIFO_DEPTH);
   assign push_ok   = push && (!full || pop);
   assign drop      = push && !push_ok;
   assign count_nx  = count + (AW+1)'(push_ok) - (AW+1)'(pop);

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         state <= IDLE;
         acc   <= '0;
         err   <= 1'b0;
      end else begin
         if (accept) begin
            acc   <= nxt;
            state <= eom ? IDLE : IN_INST;
         end
         err <= err | proto_err | (vld && bad_type) | drop;
      end
   end

   // Stall leaves room for the two words already in flight upstream.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         stall  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= nxt;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nx;
         stall <= count_nx >= (AW+1)'(FIFO_DEPTH - 2);
      end
   end

   assign head                      = mem[rd_ptr];
   assign bus.wud__odc__valid       = count != '0;
   assign bus.wud__odc__op          = head.op;
   assign bus.wud__odc__num_lanes   = head.lanes;
   assign bus.wud__odc__stream_size = head.ssize;
   assign bus.wud__odc__tgt         = head.tgt;
   assign bus.wud__wuf__stall       = stall;
   assign bus.wud__sys__err         = err;
`ifdef WU_DECODE_DESC_COUNT_EN
   assign bus.wud__odc__desc_count  = head.dcnt;
`endif

   assign unused_ok = ^{sys__mgr__mgrId, bus.wum__wud__dcntl};
endmodule
